mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter_pkg.sv | 30 +++
 rtl/mem_arbiter_rr2.sv | 21 ++
 rtl/mem_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_pkg
// Purpose  : Shared definitions for the two-master RAM arbiter: access size
//            codes, arbiter state encodings, the poison word returned for a
//            rejected (misaligned) read and the alignment rule itself.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

  // Access size codes as used on the core ram bus
  localparam logic [1:0] MEM_B = 2'd0;
  localparam logic [1:0] MEM_H = 2'd1;
  localparam logic [1:0] MEM_W = 2'd2;

  // Arbiter state encodings
  localparam logic [0:0] ARB_ST_ARB   = 1'b0;
  localparam logic [0:0] ARB_ST_BURST = 1'b1;

  // Data returned for a read that was acknowledged but never sent to the RAM
  localparam logic [31:0] MEMARB_BAD_RDATA = 32'hDEADBEEF;

  // Halfwords must be 2-byte aligned, words 4-byte aligned
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lsb);
    return ((size == MEM_H) && lsb[0]) || ((size == MEM_W) && (lsb != 2'b00));
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_rr2.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_rr2
// Purpose  : Two-way round-robin picker. A lone requester always wins; on a
//            tie the requester that was NOT granted last wins.
// Ports    : req[1:0] - request vector (bit index = master index)
//            last     - index of the most recently granted master
//            gnt[1:0] - one-hot (or zero) grant
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter_rr2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  assign gnt[0] = req[0] & (~req[1] |  last);
  assign gnt[1] = req[1] & (~req[0] | ~last);

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one single-port synchronous RAM between the core data
//            bus (m0) and a DMA/debug master with burst support (m1).
//            Grants are combinational in the request cycle; read data comes
//            back one cycle after an accepted read and is steered to the
//            master that issued it. A granted m1 access with len != 0 opens
//            an exclusive burst of up to MAX_BURST beats.
// Config   : MEMARB_ALIGN_CHK_EN - when defined, misaligned H/W accesses are
//            acknowledged but not forwarded; o_err pulses the next cycle and a
//            misaligned read returns MEMARB_BAD_RDATA. Undefined: pass-through,
//            o_err tied low.
// Ports    : clk, rst_n (async, active low)
//            i_m0_* / o_m0_* - core master request, grant, stall, read return
//            i_m1_* / o_m1_* - DMA master request (+ burst len), grant, return
//            o_mem_* / i_mem_rdata - RAM side
//            o_err - misaligned-access pulse
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 16,
  parameter int AW        = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_m0_req,
  input  logic          i_m0_wr,
  input  logic [1:0]    i_m0_size,
  input  logic [AW-1:0] i_m0_addr,
  input  logic [31:0]   i_m0_wdata,
  output logic          o_m0_gnt,
  output logic          o_m0_stall,
  output logic          o_m0_rvalid,
  output logic [31:0]   o_m0_rdata,
  input  logic          i_m1_req,
  input  logic          i_m1_wr,
  input  logic [1:0]    i_m1_size,
  input  logic [AW-1:0] i_m1_addr,
  input  logic [31:0]   i_m1_wdata,
  input  logic [7:0]    i_m1_len,
  output logic          o_m1_gnt,
  output logic          o_m1_rvalid,
  output logic [31:0]   o_m1_rdata,
  output logic          o_mem_en,
  output logic          o_mem_wr,
  output logic [1:0]    o_mem_size,
  output logic [AW-1:0] o_mem_addr,
  output logic [31:0]   o_mem_wdata,
  input  logic [31:0]   i_mem_rdata,
  output logic          o_err
);

  // Beats remaining after the opening beat are capped at MAX_BURST-1
  localparam logic [7:0] BURST_CAP = 8'(MAX_BURST - 1);

  logic [0:0]    state;
  logic          rr_last;
  logic          rd_pend;
  logic          rd_owner;
  logic [7:0]    beat_cnt;

  logic [1:0]    rr_gnt;
  logic [1:0]    gnt;
  logic          granted;
  logic          sel_wr;
  logic [1:0]    sel_size;
  logic [AW-1:0] sel_addr;
  logic [31:0]   sel_wdata;
  logic          bad_align;
  logic [31:0]   ret_data;

  mem_arbiter_rr2 u_rr2 (
    .req  ({i_m1_req, i_m0_req}),
    .last (rr_last),
    .gnt  (rr_gnt)
  );

  // Grants are held off while reset is asserted so nothing reaches the RAM
  always_comb begin
    gnt = 2'b00;
    if (rst_n) begin
      if (state == ARB_ST_BURST) gnt = {i_m1_req, 1'b0};
      else                       gnt = rr_gnt;
    end
  end

  assign granted = |gnt;

  always_comb begin
    sel_wr    = 1'b0;
    sel_size  = 2'b00;
    sel_addr  = '0;
    sel_wdata = 32'h0;
    if (gnt[1]) begin
      sel_wr    = i_m1_wr;
      sel_size  = i_m1_size;
      sel_addr  = i_m1_addr;
      sel_wdata = i_m1_wdata;
    end else if (gnt[0]) begin
      sel_wr    = i_m0_wr;
      sel_size  = i_m0_size;
      sel_addr  = i_m0_addr;
      sel_wdata = i_m0_wdata;
    end
  end

`ifdef MEMARB_ALIGN_CHK_EN
  logic rd_bad;
  logic err_q;

  assign bad_align = granted & misaligned(sel_size, sel_addr[1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_bad <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      rd_bad <= bad_align & ~sel_wr;
      err_q  <= bad_align;
    end
  end

  assign ret_data = rd_bad ? MEMARB_BAD_RDATA : i_mem_rdata;
  assign o_err    = err_q;
`else
  assign bad_align = 1'b0;
  assign ret_data  = i_mem_rdata;
  assign o_err     = 1'b0;
`endif

  assign o_mem_en    = granted & ~bad_align;
  assign o_mem_wr    = sel_wr & o_mem_en;
  assign o_mem_size  = sel_size;
  assign o_mem_addr  = sel_addr;
  assign o_mem_wdata = sel_wdata;

  assign o_m0_gnt    = gnt[0];
  assign o_m1_gnt    = gnt[1];
  assign o_m0_stall  = i_m0_req & ~gnt[0] & rst_n;

  assign o_m0_rvalid = rd_pend & ~rd_owner;
  assign o_m1_rvalid = rd_pend &  rd_owner;
  assign o_m0_rdata  = o_m0_rvalid ? ret_data : 32'h0;
  assign o_m1_rdata  = o_m1_rvalid ? ret_data : 32'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ARB_ST_ARB;
      rr_last  <= 1'b1;
      rd_pend  <= 1'b0;
      rd_owner <= 1'b0;
      beat_cnt <= 8'd0;
    end else begin
      // Misaligned reads still return (poisoned) data, so rd_pend ignores bad_align
      rd_pend <= granted & ~sel_wr;
      if (granted) begin
        rd_owner <= gnt[1];
        rr_last  <= gnt[1];
      end
      case (state)
        ARB_ST_ARB: begin
          if (gnt[1] && (i_m1_len != 8'd0)) begin
            beat_cnt <= (i_m1_len > BURST_CAP) ? BURST_CAP : i_m1_len;
            state    <= ARB_ST_BURST;
          end
        end
        default: begin
          // beat_cnt == 1 with m1 requesting means this grant is the last beat
          if (!i_m1_req || (beat_cnt == 8'd1)) begin
            state    <= ARB_ST_ARB;
            beat_cnt <= 8'd0;
            rr_last  <= 1'b1;
          end else begin
            beat_cnt <= beat_cnt - 8'd1;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter. A word-wide RAM model
//            answers the DUT's memory port; a behavioural reference (tie
//            favourite, beats left in the current burst, expected read
//            return, shadow memory) predicts every output each cycle.
//            Directed scenarios pin the reference with literal values, then
//            randomized traffic with occasional resets runs against it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int MAX_BURST = 16;
  localparam int AW        = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          m0_req, m0_wr, m1_req, m1_wr;
  logic [1:0]    m0_size, m1_size;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [31:0]   m0_wdata, m1_wdata;
  logic [7:0]    m1_len;
  logic          m0_gnt, m0_stall, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0]   m0_rdata, m1_rdata;
  logic          mem_en, mem_wr, err;
  logic [1:0]    mem_size;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.MAX_BURST(MAX_BURST), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_m0_req(m0_req), .i_m0_wr(m0_wr), .i_m0_size(m0_size), .i_m0_addr(m0_addr),
    .i_m0_wdata(m0_wdata), .o_m0_gnt(m0_gnt), .o_m0_stall(m0_stall),
    .o_m0_rvalid(m0_rvalid), .o_m0_rdata(m0_rdata),
    .i_m1_req(m1_req), .i_m1_wr(m1_wr), .i_m1_size(m1_size), .i_m1_addr(m1_addr),
    .i_m1_wdata(m1_wdata), .i_m1_len(m1_len), .o_m1_gnt(m1_gnt),
    .o_m1_rvalid(m1_rvalid), .o_m1_rdata(m1_rdata),
    .o_mem_en(mem_en), .o_mem_wr(mem_wr), .o_mem_size(mem_size), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata), .o_err(err)
  );

  function automatic logic [31:0] init_word(input int i);
    if (i == 64) return 32'h11223344;
    return {8'(i), 8'(~i), 8'(i ^ 8'h5A), 8'hC3};
  endfunction

  // RAM model: 256 words indexed by addr[9:2], read data one cycle later
  logic [31:0] ram [256];
  bit          loaded = 1'b0;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int k = 0; k < 256; k++) ram[k] <= init_word(k);
      loaded <= 1'b1;
    end else if (mem_en) begin
      if (mem_wr) ram[mem_addr[9:2]] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr[9:2]];
    end
  end

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  int          burst_left = 0;   // exclusive m1 beats still owed
  bit          favor = 1'b0;     // master that wins the next tie
  bit          rv0 = 1'b0, rv1 = 1'b0, err_n = 1'b0;
  logic [31:0] rv_data = 32'h0;
  logic [31:0] shadow [256];
  bit          mg0, mg1;         // model grants of the last cycle

  // Snapshots of the DUT outputs of the last cycle
  bit          s_g0, s_g1, s_stall, s_en, s_rv0, s_rv1, s_err;
  logic [31:0] s_addr, s_rd0, s_rd1;

  task automatic drv0(input bit req, input bit wr, input logic [1:0] sz,
                      input logic [31:0] ad, input logic [31:0] wd);
    m0_req = req; m0_wr = wr; m0_size = sz; m0_addr = ad; m0_wdata = wd;
  endtask

  task automatic drv1(input bit req, input bit wr, input logic [1:0] sz,
                      input logic [31:0] ad, input logic [31:0] wd, input logic [7:0] len);
    m1_req = req; m1_wr = wr; m1_size = sz; m1_addr = ad; m1_wdata = wd; m1_len = len;
  endtask

  // Called right after inputs are set at a negedge: check, advance model, move to next negedge
  task automatic cycle();
    bit            e_g0, e_g1, mis, e_en, wr;
    logic [1:0]    sz;
    logic [AW-1:0] ad;
    logic [31:0]   wd;
    #1;
    if (!rst_n) begin
      burst_left = 0; favor = 1'b0; rv0 = 1'b0; rv1 = 1'b0; err_n = 1'b0;
    end
    e_g0 = 1'b0; e_g1 = 1'b0;
    if (rst_n) begin
      if (burst_left > 0)          e_g1 = m1_req;
      else if (m0_req && m1_req) begin e_g0 = ~favor; e_g1 = favor; end
      else begin e_g0 = m0_req; e_g1 = m1_req; end
    end
    wr = e_g1 ? m1_wr : m0_wr;
    sz = e_g1 ? m1_size : m0_size;
    ad = e_g1 ? m1_addr : m0_addr;
    wd = e_g1 ? m1_wdata : m0_wdata;
    mis = 1'b0;
`ifdef MEMARB_ALIGN_CHK_EN
    mis = (e_g0 | e_g1) && ((sz == MEM_H && ad[0]) || (sz == MEM_W && ad[1:0] != 2'b00));
`endif
    e_en = (e_g0 | e_g1) & ~mis;

    chk("m0_gnt", {31'h0, m0_gnt}, {31'h0, e_g0});
    chk("m1_gnt", {31'h0, m1_gnt}, {31'h0, e_g1});
    chk("m0_stall", {31'h0, m0_stall}, {31'h0, m0_req & ~e_g0 & rst_n});
    chk("mem_en", {31'h0, mem_en}, {31'h0, e_en});
    chk("mem_wr", {31'h0, mem_wr}, {31'h0, e_en & wr});
    if (e_en) begin
      chk("mem_addr", mem_addr, ad);
      chk("mem_size", {30'h0, mem_size}, {30'h0, sz});
      if (wr) chk("mem_wdata", mem_wdata, wd);
    end
    chk("m0_rvalid", {31'h0, m0_rvalid}, {31'h0, rv0});
    chk("m1_rvalid", {31'h0, m1_rvalid}, {31'h0, rv1});
    chk("m0_rdata", m0_rdata, rv0 ? rv_data : 32'h0);
    chk("m1_rdata", m1_rdata, rv1 ? rv_data : 32'h0);
    chk("err", {31'h0, err}, {31'h0, err_n});

    s_g0 = m0_gnt; s_g1 = m1_gnt; s_stall = m0_stall; s_en = mem_en; s_addr = mem_addr;
    s_rv0 = m0_rvalid; s_rv1 = m1_rvalid; s_rd0 = m0_rdata; s_rd1 = m1_rdata; s_err = err;
    mg0 = e_g0; mg1 = e_g1;

    if (rst_n) begin
      rv0 = e_g0 & ~wr;
      rv1 = e_g1 & ~wr;
      if ((e_g0 | e_g1) && !wr) rv_data = mis ? 32'hDEADBEEF : shadow[ad[9:2]];
      if (e_en && wr) shadow[ad[9:2]] = wd;
      err_n = mis;
      if (burst_left > 0) begin
        burst_left = m1_req ? burst_left - 1 : 0;
        favor = 1'b0;
      end else if (e_g1) begin
        favor = 1'b0;
        if (m1_len != 8'd0) burst_left = (int'(m1_len) > MAX_BURST - 1) ? MAX_BURST - 1 : int'(m1_len);
      end else if (e_g0) begin
        favor = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drv0(0, 0, MEM_W, 32'h0, 32'h0);
    drv1(0, 0, MEM_W, 32'h0, 32'h0, 8'd0);
    cycle();
    rst_n = 1'b1;
  endtask

  // Burst scenario: m0 granted once (m1 then wins the tie), then m1 bursts against m0
  task automatic burst_case(input logic [7:0] len, input int exp_beats, input string tag);
    int m1cnt, stalls, m0_at;
    do_reset();
    drv0(1, 1, MEM_W, 32'h308, 32'hA5A5_0001);
    cycle();
    drv1(1, 1, MEM_W, 32'h30C, 32'h5A5A_0002, len);
    m1cnt = 0; stalls = 0; m0_at = 0;
    for (int n = 1; n <= exp_beats + 8; n++) begin
      cycle();
      if (s_g1) m1cnt++;
      if (s_stall) stalls++;
      if (s_g0) begin m0_at = n; break; end
    end
    chk({tag, "_m1_beats"}, 32'(m1cnt), 32'(exp_beats));
    chk({tag, "_m0_stalls"}, 32'(stalls), 32'(exp_beats));
    chk({tag, "_m0_grant_cycle"}, 32'(m0_at), 32'(exp_beats + 1));
    drv0(0, 0, MEM_W, 32'h0, 32'h0);
    drv1(0, 0, MEM_W, 32'h0, 32'h0, 8'd0);
    cycle();
  endtask

  initial begin
    bit            p0, p1;
    logic [31:0]   ra;
    logic [7:0]    rl;
    for (int k = 0; k < 256; k++) shadow[k] = init_word(k);
    drv0(0, 0, MEM_W, 32'h0, 32'h0);
    drv1(0, 0, MEM_W, 32'h0, 32'h0, 8'd0);
    @(negedge clk);

    // Reset state: request held during reset must not be granted
    drv0(1, 0, MEM_W, 32'h100, 32'h0);
    cycle();
    chk("rst_m0_gnt", {31'h0, s_g0}, 32'h0);
    chk("rst_mem_en", {31'h0, s_en}, 32'h0);
    chk("rst_m0_rvalid", {31'h0, s_rv0}, 32'h0);
    cycle();
    rst_n = 1'b1;

    // Single m0 read at 0x100: granted same cycle, data next cycle
    cycle();
    chk("t1_gnt", {31'h0, s_g0}, 32'h1);
    chk("t1_stall", {31'h0, s_stall}, 32'h0);
    chk("t1_addr", s_addr, 32'h100);
    drv0(0, 0, MEM_W, 32'h0, 32'h0);
    cycle();
    chk("t1_rvalid", {31'h0, s_rv0}, 32'h1);
    chk("t1_rdata", s_rd0, 32'h11223344);

    // Simultaneous requests from reset alternate starting with m0
    do_reset();
    drv0(1, 1, MEM_W, 32'h300, 32'h1);
    drv1(1, 1, MEM_W, 32'h304, 32'h2, 8'd0);
    for (int c = 0; c < 4; c++) begin
      cycle();
      chk("alt_m0_gnt", {31'h0, s_g0}, (c % 2 == 0) ? 32'h1 : 32'h0);
      chk("alt_m1_gnt", {31'h0, s_g1}, (c % 2 == 1) ? 32'h1 : 32'h0);
      chk("alt_stall", {31'h0, s_stall}, (c % 2 == 1) ? 32'h1 : 32'h0);
    end

    burst_case(8'd3, 4, "burst4");
    burst_case(8'd40, MAX_BURST, "burst_cap");

    // Interleaved reads m0@0 then m1@4
    do_reset();
    drv0(1, 0, MEM_W, 32'h0, 32'h0);
    cycle();
    drv0(0, 0, MEM_W, 32'h0, 32'h0);
    drv1(1, 0, MEM_W, 32'h4, 32'h0, 8'd0);
    cycle();
    chk("il_m0_rvalid", {31'h0, s_rv0}, 32'h1);
    chk("il_m0_rdata", s_rd0, init_word(0));
    drv1(0, 0, MEM_W, 32'h0, 32'h0, 8'd0);
    cycle();
    chk("il_m1_rvalid", {31'h0, s_rv1}, 32'h1);
    chk("il_m1_rdata", s_rd1, init_word(1));
    chk("il_m0_quiet", {31'h0, s_rv0}, 32'h0);

    // Reset with a read pending kills the return
    drv0(1, 0, MEM_W, 32'h8, 32'h0);
    cycle();
    drv0(0, 0, MEM_W, 32'h0, 32'h0);
    rst_n = 1'b0;
    cycle();
    chk("rstpend_rvalid", {31'h0, s_rv0}, 32'h0);
    rst_n = 1'b1;
    cycle();
    chk("rstpend_after_m0", {31'h0, s_rv0}, 32'h0);
    chk("rstpend_after_m1", {31'h0, s_rv1}, 32'h0);

`ifdef MEMARB_ALIGN_CHK_EN
    do_reset();
    drv0(1, 0, MEM_W, 32'h102, 32'h0);
    cycle();
    chk("al_gnt", {31'h0, s_g0}, 32'h1);
    chk("al_mem_en", {31'h0, s_en}, 32'h0);
    drv0(0, 0, MEM_W, 32'h0, 32'h0);
    cycle();
    chk("al_err", {31'h0, s_err}, 32'h1);
    chk("al_rvalid", {31'h0, s_rv0}, 32'h1);
    chk("al_rdata", s_rd0, 32'hDEADBEEF);
`endif

    // Randomized traffic; requests are held until the model says granted
    p0 = 1'b0; p1 = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      if (!p0) begin
        if ($urandom_range(0, 99) < 55) begin
          ra = $urandom;
`ifndef MEMARB_ALIGN_CHK_EN
          ra[1:0] = 2'b00;
`endif
          drv0(1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), ra, $urandom);
          p0 = 1'b1;
        end else begin
          m0_req = 1'b0;
        end
      end
      if (!p1) begin
        if ($urandom_range(0, 99) < ((burst_left > 0) ? 90 : 45)) begin
          ra = $urandom;
`ifndef MEMARB_ALIGN_CHK_EN
          ra[1:0] = 2'b00;
`endif
          case ($urandom_range(0, 3))
            0:       rl = 8'd0;
            1:       rl = 8'($urandom_range(1, 5));
            2:       rl = 8'($urandom_range(0, 255));
            default: rl = 8'd40;
          endcase
          drv1(1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), ra, $urandom, rl);
          p1 = 1'b1;
        end else begin
          m1_req = 1'b0;
        end
      end
      cycle();
      if (mg0) p0 = 1'b0;
      if (mg1) p1 = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
